thermo_bist_ctrl: RTL and testbench
===================================

THERMO_BIST_CTRL -- requirements
Module: thermo_bist_ctrl

Interface
REQ-001 Parameter K, default 3: encoder input and decoder output width in bits.
REQ-002 Parameter W, default 7: thermometer code width; SHALL equal 2^K-1.
REQ-003 Parameter LAT, default 1: registered latency of the encoder and decoder datapaths, in clock cycles; legal range 1..7.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  run request, sampled only in IDLE and DONE.
REQ-007 enc_q  input  W  thermometer encoder output under test.
REQ-008 dec_q  input  K  thermometer decoder output under test.
REQ-009 enc_a  output  K  registered stimulus to the encoder input.
REQ-010 dec_a  output  W  registered stimulus to the decoder input.
REQ-011 busy  output  1  high while the sweep is in progress.
REQ-012 done  output  1  high while the result is held.
REQ-013 pass  output  1  result flag, meaningful only when done=1.
REQ-014 fail_code  output  K  vector index v of the first mismatch; 0 on pass.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WAIT, CHECK and DONE.
REQ-016 Definition: T(v) is the W-bit thermometer code of v, with bits [v-1:0]=1 and all other bits 0; T(0)=0 and T(W)=all ones.
REQ-017 IDLE, start=1: on that edge, v:=0, enc_a:=0, dec_a:=0, wait counter:=LAT+1, next state WAIT.
REQ-018 IDLE, start=0: the FSM SHALL remain in IDLE.
REQ-019 WAIT: the wait counter SHALL decrement once per cycle; on the edge where it reaches 0, the FSM SHALL go to CHECK. WAIT therefore lasts exactly LAT+1 cycles.
REQ-020 CHECK lasts 1 cycle and SHALL compare enc_q against T(v) and dec_q against v.
REQ-021 CHECK, either compare mismatches: go to DONE with pass:=0 and fail_code:=v; the sweep stops.
REQ-022 CHECK, both compares match and v==W: go to DONE with pass:=1 and fail_code:=0.
REQ-023 CHECK, both compares match and v<W: v:=v+1, enc_a:=v+1, dec_a:=T(v+1), wait counter:=LAT+1, next state WAIT.
REQ-024 The v counter SHALL be K+1 bits wide so that the v==W test never wraps; enc_a SHALL carry v[K-1:0].
REQ-025 Each vector SHALL take exactly LAT+2 cycles.
REQ-026 done SHALL first be high 1+(W+1)*(LAT+2) rising edges after the edge that samples start; for the defaults this is 25 edges.
REQ-027 busy SHALL equal 1 in WAIT and CHECK, and 0 in IDLE and DONE.
REQ-028 done SHALL equal 1 only in DONE.
REQ-029 DONE SHALL hold pass, fail_code, enc_a and dec_a stable.
REQ-030 DONE, start=1: identical action to REQ-017; pass and fail_code SHALL clear to 0 on that same edge.
REQ-031 start while busy=1 SHALL be ignored, with no restart and no state change.
REQ-032 enc_q and dec_q SHALL be ignored outside CHECK.
REQ-033 No combinational path SHALL exist from any input to any output; all outputs are registers.

Reset
REQ-034 While rst=1, independent of clk: state=IDLE, v=0, wait counter=0, enc_a=0, dec_a=0, busy=0, done=0, pass=0, fail_code=0.
REQ-035 rst asserted mid-sweep SHALL abort the sweep immediately; after release the block SHALL wait in IDLE for a new start.
REQ-036 The first edge after rst deasserts SHALL be treated as an ordinary IDLE cycle.

Verification
REQ-037 Ideal encoder and decoder models (LAT=1, K=3, W=7), start pulsed 1 cycle -> busy high for 24 cycles; done=1, pass=1, fail_code=0 at edge 25.
REQ-038 Decoder model returns 3 when its input is T(5) -> done=1, pass=0, fail_code=5; total cycles 1+6*3=19.
REQ-039 Encoder model has enc_q[0] stuck at 0 -> fail at v=1: pass=0, fail_code=1, done at edge 7.
REQ-040 Mid-sweep tests: rst pulsed at cycle 10 -> all outputs 0 asynchronously and IDLE held; separately, start held high during a sweep -> sweep timing unchanged.
REQ-041 After a pass, start pulsed again -> pass and fail_code clear on that edge and the sweep repeats with identical timing.
REQ-042 LAT=3 build with ideal models -> done at edge 1+8*5=41 with pass=1.

Source files
------------

// File: rtl/thermo_bist_ctrl.sv
// thermo_bist_ctrl: built-in self test sequencer for a thermometer encoder /
// decoder pair. Sweeps v = 0..W, drives enc_a = v and dec_a = T(v), waits
// LAT+1 cycles for the datapaths, then checks enc_q == T(v) and dec_q == v.
// Stops at the first mismatch or after the last vector.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : run request, sampled only in IDLE and DONE
//   enc_q, dec_q  : encoder / decoder outputs under test
//   enc_a, dec_a  : registered stimulus to encoder / decoder
//   busy, done    : sweep in progress / result held
//   pass          : result flag, valid while done = 1
//   fail_code     : vector index of first mismatch, 0 on pass
module thermo_bist_ctrl #(
    parameter int unsigned K   = 3,
    parameter int unsigned W   = 7,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] enc_q,
    input  logic [K-1:0] dec_q,
    output logic [K-1:0] enc_a,
    output logic [W-1:0] dec_a,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [K-1:0] fail_code
);

    localparam int unsigned VW = K + 1;  // one extra bit so v == W never wraps
    localparam int unsigned CW = 4;      // holds LAT+1 up to 8

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [VW-1:0]   v, v_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [K-1:0]    enc_a_nxt;
    logic [W-1:0]    dec_a_nxt;
    logic            busy_nxt, done_nxt, pass_nxt;
    logic [K-1:0]    fail_code_nxt;

    // Thermometer code of n: bits [n-1:0] set.
    function automatic logic [W-1:0] therm(input logic [VW-1:0] n);
        logic [W-1:0] t;
        for (int i = 0; i < int'(W); i++) begin
            t[i] = (VW'(i) < n);
        end
        return t;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            v         <= '0;
            cnt       <= '0;
            enc_a     <= '0;
            dec_a     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
        end else begin
            state     <= state_nxt;
            v         <= v_nxt;
            cnt       <= cnt_nxt;
            enc_a     <= enc_a_nxt;
            dec_a     <= dec_a_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            fail_code <= fail_code_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        v_nxt         = v;
        cnt_nxt       = cnt;
        enc_a_nxt     = enc_a;
        dec_a_nxt     = dec_a;
        pass_nxt      = pass;
        fail_code_nxt = fail_code;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt     = WAIT;
                    v_nxt         = '0;
                    cnt_nxt       = CW'(LAT + 1);
                    enc_a_nxt     = '0;
                    dec_a_nxt     = '0;
                    pass_nxt      = 1'b0;
                    fail_code_nxt = '0;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CW'(1);
                // Leave on the edge where the counter reaches zero.
                if (cnt <= CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if ((enc_q != therm(v)) || (dec_q != v[K-1:0])) begin
                    state_nxt     = DONE;
                    pass_nxt      = 1'b0;
                    fail_code_nxt = v[K-1:0];
                end else if (v == VW'(W)) begin
                    state_nxt     = DONE;
                    pass_nxt      = 1'b1;
                    fail_code_nxt = '0;
                end else begin
                    state_nxt = WAIT;
                    v_nxt     = v + VW'(1);
                    enc_a_nxt = v_nxt[K-1:0];
                    dec_a_nxt = therm(v_nxt);
                    cnt_nxt   = CW'(LAT + 1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == WAIT) || (state_nxt == CHECK);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_thermo_bist_ctrl.sv
// Self-checking bench for thermo_bist_ctrl: behavioural encoder/decoder models
// with selectable faults, scoreboard of expected sweep results.
module tb_thermo_bist_ctrl;

    localparam int unsigned K = 3;
    localparam int unsigned W = 7;

    logic clk = 1'b0;
    logic rst;
    logic start, start3;
    logic [W-1:0] enc_q, enc_q3;
    logic [K-1:0] dec_q, dec_q3;
    logic [K-1:0] enc_a, enc_a3;
    logic [W-1:0] dec_a, dec_a3;
    logic busy, done, pass, busy3, done3, pass3;
    logic [K-1:0] fail_code, fail_code3;

    logic [1:0] mode;  // 0 ideal, 1 decoder bad on T(5), 2 enc_q[0] stuck 0

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int edges;
        int pass;
        int fcode;
        int busy_cycles;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    thermo_bist_ctrl #(.K(K), .W(W), .LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .enc_q(enc_q), .dec_q(dec_q),
        .enc_a(enc_a), .dec_a(dec_a), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code)
    );

    thermo_bist_ctrl #(.K(K), .W(W), .LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .enc_q(enc_q3), .dec_q(dec_q3),
        .enc_a(enc_a3), .dec_a(dec_a3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_code(fail_code3)
    );

    function automatic logic [W-1:0] therm_m(input int n);
        logic [W-1:0] t;
        for (int i = 0; i < int'(W); i++) t[i] = (i < n);
        return t;
    endfunction

    function automatic logic [W-1:0] enc_model(input logic [K-1:0] a, input logic [1:0] m);
        logic [W-1:0] t;
        t = therm_m(int'(a));
        if (m == 2'd2) t[0] = 1'b0;
        return t;
    endfunction

    function automatic logic [K-1:0] dec_model(input logic [W-1:0] d, input logic [1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < int'(W); i++) c += int'(d[i]);
        if (m == 2'd1 && d == therm_m(5)) c = 3;
        return K'(c);
    endfunction

    // One-stage datapath models for the LAT=1 instance.
    always_ff @(posedge clk) begin
        enc_q <= enc_model(enc_a, mode);
        dec_q <= dec_model(dec_a, mode);
    end

    // Three-stage ideal datapath models for the LAT=3 instance.
    logic [W-1:0] e3 [3];
    logic [K-1:0] d3 [3];
    always_ff @(posedge clk) begin
        e3[0] <= enc_model(enc_a3, 2'd0);
        d3[0] <= dec_model(dec_a3, 2'd0);
        for (int i = 1; i < 3; i++) begin
            e3[i] <= e3[i-1];
            d3[i] <= d3[i-1];
        end
    end
    assign enc_q3 = e3[2];
    assign dec_q3 = d3[2];

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One sweep; edges counted with the start-sampling edge as edge 1.
    task automatic run_sweep(input string tag, input logic [1:0] m, input bit hold,
                             input int exp_edges, input int exp_pass, input int exp_fc);
        exp_t e;
        int n, nb;
        mode = m;
        sb.push_back('{exp_edges, exp_pass, exp_fc, exp_edges - 1});
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        n  = 1;
        nb = int'(busy);
        check_eq({tag, "_clr_pass"}, int'(pass), 0);
        check_eq({tag, "_clr_fc"}, int'(fail_code), 0);
        if (!hold) @(negedge clk) start = 1'b0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) nb++;
        end
        e = sb.pop_front();
        check_eq({tag, "_done"}, int'(done), 1);
        check_eq({tag, "_edges"}, n, e.edges);
        check_eq({tag, "_pass"}, int'(pass), e.pass);
        check_eq({tag, "_fcode"}, int'(fail_code), e.fcode);
        check_eq({tag, "_busy"}, nb, e.busy_cycles);
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        start3 = 1'b0;
        mode = 2'd0;
        #12;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_pass", int'(pass), 0);
        check_eq("rst_fcode", int'(fail_code), 0);
        check_eq("rst_enc_a", int'(enc_a), 0);
        check_eq("rst_dec_a", int'(dec_a), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", int'(busy), 0);

        run_sweep("ideal", 2'd0, 1'b0, 25, 1, 0);
        repeat (3) @(negedge clk);
        check_eq("hold_done", int'(done), 1);
        check_eq("hold_pass", int'(pass), 1);
        check_eq("hold_enc_a", int'(enc_a), 7);
        check_eq("hold_dec_a", int'(dec_a), 127);

        run_sweep("encstuck", 2'd2, 1'b0, 7, 0, 1);
        check_eq("encstuck_enc_a", int'(enc_a), 1);
        check_eq("encstuck_dec_a", int'(dec_a), 1);
        run_sweep("decbad", 2'd1, 1'b0, 19, 0, 5);
        run_sweep("hold", 2'd0, 1'b1, 25, 1, 0);
        run_sweep("rerun", 2'd0, 1'b0, 25, 1, 0);

        // Reset mid-sweep: outputs clear without a clock edge, then IDLE holds.
        mode = 2'd0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_pass", int'(pass), 0);
        check_eq("abort_enc_a", int'(enc_a), 0);
        check_eq("abort_dec_a", int'(dec_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("post_abort_busy", int'(busy), 0);
        check_eq("post_abort_done", int'(done), 0);

        // LAT=3 instance.
        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        @(negedge clk) start3 = 1'b0;
        while (!done3 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("lat3_edges", n, 41);
        check_eq("lat3_pass", int'(pass3), 1);
        check_eq("lat3_fcode", int'(fail_code3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
